usb_tx_arb: RTL and testbench
=============================

Name: usb_tx_arb

Overview:
- Packet-level transmit scheduler in front of the UTM transmit side.
- Arbitrates between one handshake requester and EP_N data-endpoint requesters.
- For the granted requester, sequences PID, payload and CRC16 bytes onto the UTMI tx byte interface (data_in/tx_valid/tx_ready).
- Enforces a minimum inter-packet gap before the next grant.

Parameters:
EP_N, 4, number of data-endpoint requesters (1..8)
MAX_PKT, 64, maximum payload bytes per packet; longer payloads are truncated
IPG_CLKS, 16, idle clocks inserted after tx_valid falls before the next grant

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
tx_en  in  1  grant enable; when low no new packet starts
hs_req  in  1  handshake packet request (level, held until hs_done)
hs_pid  in  4  handshake PID (ACK/NAK/STALL), stable while hs_req
hs_done  out  1  one-cycle pulse: handshake PID accepted by UTM
ep_req  in  EP_N  data packet request per endpoint (level, held until ep_done)
ep_pid  in  4*EP_N  DATA0/DATA1 PID per endpoint
ep_zlp  in  EP_N  request is a zero-length packet
ep_data  in  8*EP_N  current payload byte per endpoint
ep_last  in  EP_N  current byte is the final payload byte
ep_rd  out  EP_N  one-cycle pulse: current byte consumed; next byte due the following cycle
ep_done  out  EP_N  one-cycle pulse: packet including CRC fully accepted
ep_trunc  out  EP_N  one-cycle pulse with ep_done: payload cut at MAX_PKT
data_in  out  8  UTMI transmit byte
tx_valid  out  1  UTMI transmit valid
tx_ready  in  1  UTMI byte accepted
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (async on rst_n low, including mid-packet): all outputs 0; FSM in IDLE; round-robin pointer at endpoint 0.
- A byte transfers on a cycle where tx_valid && tx_ready. data_in changes only in the cycle after a transfer. tx_valid stays high, without gaps, from the PID through the final byte.
- PID byte encoding is {~pid, pid}.
- FSM states: IDLE, PID, DATA, CRC_LO, CRC_HI, GAP.
- IDLE, when tx_en is high:
  - hs_req has absolute priority: grant HS, go to PID.
  - Otherwise grant the next requesting endpoint round-robin, starting at pointer+1 (pointer = last granted endpoint), go to PID.
  - The grant is registered and locked until GAP. Request or tx_en changes mid-packet are ignored.
- PID: tx_valid=1. On transfer:
  - HS grant: pulse hs_done, deassert tx_valid, go to GAP.
  - EP with ep_zlp: go to CRC_LO.
  - EP otherwise: go to DATA.
- DATA: data_in = ep_data[g]; ep_rd[g] = transfer (combinational). Each byte updates the CRC and increments an 8-bit-capable payload counter. On transfer:
  - If ep_last[g]: go to CRC_LO.
  - Else if count reaches MAX_PKT: go to CRC_LO and flag truncation.
- CRC_LO / CRC_HI: send ~crc[7:0], then ~crc[15:8].
  - CRC16/USB: reflected poly 0xA001, init 0xFFFF, reinitialised at PID.
  - On CRC_HI transfer: deassert tx_valid next cycle, pulse ep_done[g] (with ep_trunc[g] if flagged), go to GAP.
- GAP: tx_valid=0. Hold IPG_CLKS cycles, then go to IDLE; a new grant is possible on the following cycle.
- A ZLP sends PID, 0x00, 0x00.
- With EP_N requests all asserted, grants cycle 0,1,2,…,EP_N-1,0. Pointer wrap-around from EP_N-1 to 0.
- Simultaneous hs_req and ep_req: HS wins; the EP pointer is unchanged.
- tx_ready high while tx_valid is low is ignored.

Decomposition:
- usb_utmi_pkg additions:
  - usb_pid_t enum (ACK=4'b0010, NAK=4'b1010, STALL=4'b1110, DATA0=4'b0011, DATA1=4'b1011)
  - USB_CRC16_POLY=16'hA001
  - USB_CRC16_INIT=16'hFFFF
  - tx_arb state enum
- Sub-module usb_crc16: byte-wise combinational-next/registered CRC with init and update-enable inputs.
- Arbiter, payload counter, gap counter and FSM live in usb_tx_arb.

Test Plan:
- hs_req=1, hs_pid=ACK, tx_ready every 4th cycle -> exactly one byte 0xD2 with tx_valid; hs_done pulses once; tx_valid low for ≥IPG_CLKS cycles afterwards.
- ep_req[1], DATA0, payload "123456789" (0x31..0x39, ep_last on 0x39) -> bytes C3 31..39 C8 B4; 9 ep_rd[1] pulses; one ep_done[1] pulse; no ep_trunc.
- ep_req[2], ep_zlp, DATA1 -> bytes 4B 00 00; no ep_rd; ep_done[2].
- ep_req all 1, hs_req raised during EP0 packet -> order EP0, HS, EP1, EP2, EP3, EP0; HS is not inserted mid-packet.
- MAX_PKT=4, payload 6 bytes without ep_last -> 4 data bytes, then CRC; ep_done with ep_trunc.
- rst_n low during DATA byte 3 -> tx_valid=0 immediately; after release, a fresh request starts with its PID.

Source files
------------

// File: rtl/usb_utmi_pkg.sv
// Shared UTMI transmit-side types: PID codes, CRC16/USB constants, tx arbiter states
// and a byte-wise CRC16 helper.
package usb_utmi_pkg;

  typedef enum logic [3:0] {
    ACK   = 4'b0010,
    NAK   = 4'b1010,
    STALL = 4'b1110,
    DATA0 = 4'b0011,
    DATA1 = 4'b1011
  } usb_pid_t;

  localparam logic [15:0] USB_CRC16_POLY = 16'hA001;
  localparam logic [15:0] USB_CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_GAP
  } tx_arb_state_t;

  // Reflected CRC16: the register LSB corresponds to the first bit on the wire.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ USB_CRC16_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Registered CRC16/USB accumulator; init has priority over update, result valid the
// cycle after an update. No flow control of its own: the caller gates upd on a transfer.
module usb_crc16
  import usb_utmi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        upd,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = USB_CRC16_INIT;
    end else if (upd) begin
      crc_d = crc16_byte(crc_q, data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= USB_CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_tx_arb.sv
// Packet scheduler for the UTMI tx byte port: handshake-first, round-robin endpoints, PID/payload/CRC16 sequencing.
// Grant one clock after a request in IDLE; stalls byte-by-byte on tx_ready, then holds IPG_CLKS idle clocks.
module usb_tx_arb
  import usb_utmi_pkg::*;
#(
  parameter int EP_N     = 4,
  parameter int MAX_PKT  = 64,
  parameter int IPG_CLKS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic              hs_req,
  input  logic [3:0]        hs_pid,
  output logic              hs_done,
  input  logic [EP_N-1:0]   ep_req,
  input  logic [4*EP_N-1:0] ep_pid,
  input  logic [EP_N-1:0]   ep_zlp,
  input  logic [8*EP_N-1:0] ep_data,
  input  logic [EP_N-1:0]   ep_last,
  output logic [EP_N-1:0]   ep_rd,
  output logic [EP_N-1:0]   ep_done,
  output logic [EP_N-1:0]   ep_trunc,
  output logic [7:0]        data_in,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  localparam int PW = (EP_N > 1) ? $clog2(EP_N) : 1;
  localparam int GW = (IPG_CLKS > 1) ? $clog2(IPG_CLKS) : 1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_PKT);

  tx_arb_state_t   state_q;
  logic            gnt_hs_q;
  logic [PW-1:0]   gnt_q, ptr_q;
  logic [3:0]      pid_q;
  logic [7:0]      cnt_q;
  logic [GW-1:0]   gap_q;
  logic            trunc_q, tx_valid_q, hs_done_q;
  logic [EP_N-1:0] ep_done_q, ep_trunc_q;

  logic            xfer, ep_hit, cur_last;
  logic [PW-1:0]   ep_sel, cand;
  logic [7:0]      cur_data;
  logic [15:0]     crc;

  assign xfer     = tx_valid_q && tx_ready;
  assign cur_data = ep_data[{gnt_q, 3'b000} +: 8];
  assign cur_last = ep_last[gnt_q];

  // Search starts one past the last granted endpoint so every requester gets a turn.
  always_comb begin
    ep_hit = 1'b0;
    ep_sel = '0;
    cand   = '0;
    for (int i = 1; i <= EP_N; i++) begin
      cand = PW'((int'(ptr_q) + i) % EP_N);
      if (!ep_hit && ep_req[cand]) begin
        ep_hit = 1'b1;
        ep_sel = cand;
      end
    end
  end

  always_comb begin
    data_in = 8'h00;
    case (state_q)
      ST_PID:    data_in = {~pid_q, pid_q};
      ST_DATA:   data_in = cur_data;
      ST_CRC_LO: data_in = ~crc[7:0];
      ST_CRC_HI: data_in = ~crc[15:8];
      default:   data_in = 8'h00;
    endcase
  end

  always_comb begin
    ep_rd = '0;
    if (state_q == ST_DATA && xfer) begin
      ep_rd[gnt_q] = 1'b1;
    end
  end

  usb_crc16 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (state_q == ST_PID),
    .upd   (state_q == ST_DATA && xfer),
    .data  (cur_data),
    .crc   (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_hs_q   <= 1'b0;
      gnt_q      <= '0;
      ptr_q      <= '0;
      pid_q      <= 4'h0;
      cnt_q      <= 8'h00;
      gap_q      <= '0;
      trunc_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      hs_done_q  <= 1'b0;
      ep_done_q  <= '0;
      ep_trunc_q <= '0;
    end else begin
      hs_done_q  <= 1'b0;
      ep_done_q  <= '0;
      ep_trunc_q <= '0;
      case (state_q)
        ST_IDLE: begin
          cnt_q   <= 8'h00;
          trunc_q <= 1'b0;
          if (tx_en && hs_req) begin
            gnt_hs_q   <= 1'b1;
            pid_q      <= hs_pid;
            tx_valid_q <= 1'b1;
            state_q    <= ST_PID;
          end else if (tx_en && ep_hit) begin
            gnt_hs_q   <= 1'b0;
            gnt_q      <= ep_sel;
            ptr_q      <= ep_sel;
            pid_q      <= ep_pid[{ep_sel, 2'b00} +: 4];
            tx_valid_q <= 1'b1;
            state_q    <= ST_PID;
          end
        end
        ST_PID: if (xfer) begin
          if (gnt_hs_q) begin
            hs_done_q  <= 1'b1;
            tx_valid_q <= 1'b0;
            gap_q      <= '0;
            state_q    <= ST_GAP;
          end else if (ep_zlp[gnt_q]) begin
            state_q <= ST_CRC_LO;
          end else begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: if (xfer) begin
          cnt_q <= cnt_q + 8'd1;
          if (cur_last) begin
            state_q <= ST_CRC_LO;
          end else if (cnt_q + 8'd1 == MAX_CNT) begin
            trunc_q <= 1'b1;
            state_q <= ST_CRC_LO;
          end
        end
        ST_CRC_LO: if (xfer) state_q <= ST_CRC_HI;
        ST_CRC_HI: if (xfer) begin
          tx_valid_q        <= 1'b0;
          ep_done_q[gnt_q]  <= 1'b1;
          ep_trunc_q[gnt_q] <= trunc_q;
          gap_q             <= '0;
          state_q           <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_q == GW'(IPG_CLKS - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_valid = tx_valid_q;
  assign hs_done  = hs_done_q;
  assign ep_done  = ep_done_q;
  assign ep_trunc = ep_trunc_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_tx_arb.sv
// Bench for usb_tx_arb: endpoint/handshake requester models feed a byte scoreboard,
// single-packet vectors come from a table, arbitration order and reset are hand sequences.
module tb_usb_tx_arb;

  localparam int EP_N = 4;
  localparam int MAXP = 64;
  localparam int IPG  = 16;

  logic              clk = 1'b0;
  logic              rst_n, tx_en, hs_req, hs_done, tx_valid, tx_ready, busy;
  logic [3:0]        hs_pid;
  logic [EP_N-1:0]   ep_req, ep_zlp, ep_last, ep_rd, ep_done, ep_trunc;
  logic [4*EP_N-1:0] ep_pid;
  logic [8*EP_N-1:0] ep_data;
  logic [7:0]        data_in;

  usb_tx_arb #(.EP_N(EP_N), .MAX_PKT(MAXP), .IPG_CLKS(IPG)) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .hs_req(hs_req), .hs_pid(hs_pid),
    .hs_done(hs_done), .ep_req(ep_req), .ep_pid(ep_pid), .ep_zlp(ep_zlp),
    .ep_data(ep_data), .ep_last(ep_last), .ep_rd(ep_rd), .ep_done(ep_done),
    .ep_trunc(ep_trunc), .data_in(data_in), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         hs;
    int         ep;
    logic [3:0] pid;
    bit         zlp;
    int         len;
    bit         last;
    logic [7:0] base;
    int         mode;    // tx_ready: 0 always, 1 every 4th cycle, 2 random
    bit         crc_k;   // wire CRC bytes given as a constant
    logic [15:0] crc;    // {hi, lo} as sent on the wire
    bit         trunc;
  } vec_t;

  vec_t tbl[8];
  int   n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  int   done_log[$];
  int   exp_order[6];

  int         idx_a[EP_N], len_a[EP_N], rearm[EP_N];
  bit         last_a[EP_N];
  logic [7:0] base_a[EP_N];
  int         n_rd[EP_N], n_done[EP_N], n_trunc[EP_N];
  int         n_hs, rdy_mode, cyc, low_run, n_valid;
  bit         prev_v, seen_fall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic drive_eps();
    for (int e = 0; e < EP_N; e++) begin
      ep_data[8*e +: 8] = base_a[e] + 8'(idx_a[e]);
      ep_last[e]        = last_a[e] && (idx_a[e] == len_a[e] - 1);
    end
  endtask

  task automatic push_pkt(input bit hs, input logic [3:0] pid, input int e, input int n,
                          input bit crc_k, input logic [15:0] crc_fix);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    exp_q.push_back({~pid, pid});
    if (!hs) begin
      for (int i = 0; i < n; i++) begin
        b = base_a[e] + 8'(i);
        exp_q.push_back(b);
        c = crc_upd(c, b);
      end
      c = crc_k ? crc_fix : ~c;
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
    end
  endtask

  task automatic clear_counts();
    for (int e = 0; e < EP_N; e++) begin
      n_rd[e] = 0; n_done[e] = 0; n_trunc[e] = 0;
    end
    n_hs = 0;
  endtask

  // One clock: sample at negedge, update requester models just after posedge.
  task automatic step();
    logic [EP_N-1:0] rd, dn;
    logic hsd, xfer;
    @(negedge clk);
    cyc++;
    xfer = tx_valid && tx_ready;
    rd   = ep_rd;
    dn   = ep_done;
    hsd  = hs_done;
    if (tx_valid) n_valid++;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL byte_unexpected: got 0x%0h, no byte expected", data_in);
      end else begin
        check("tx_byte", {24'h0, data_in}, {24'h0, exp_q.pop_front()});
      end
    end
    if (|rd) check("rd_needs_xfer", {31'h0, xfer}, 32'd1);
    for (int e = 0; e < EP_N; e++) begin
      if (rd[e]) n_rd[e]++;
      if (dn[e]) begin n_done[e]++; done_log.push_back(e); end
      if (ep_trunc[e]) n_trunc[e]++;
    end
    if (hsd) begin n_hs++; done_log.push_back(-1); end
    if (tx_valid) begin
      if (!prev_v && seen_fall) check("ipg_min", {31'h0, low_run >= IPG}, 32'd1);
      low_run = 0;
    end else begin
      low_run++;
    end
    if (prev_v && !tx_valid) seen_fall = 1'b1;
    prev_v = tx_valid;
    @(posedge clk);
    #1;
    for (int e = 0; e < EP_N; e++) begin
      if (rd[e]) idx_a[e]++;
      if (dn[e]) begin
        if (rearm[e] > 0) begin rearm[e]--; idx_a[e] = 0; end
        else ep_req[e] = 1'b0;
      end
    end
    if (hsd) hs_req = 1'b0;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = (cyc % 4 == 0);
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    drive_eps();
  endtask

  task automatic setup_ep(input int e, input logic [3:0] pid, input bit zlp, input int len,
                          input bit last, input logic [7:0] base);
    base_a[e] = base; len_a[e] = len; last_a[e] = last; idx_a[e] = 0;
    ep_pid[4*e +: 4] = pid;
    ep_zlp[e] = zlp;
    drive_eps();
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int n, budget, e;
    string tag;
    tag = $sformatf("vec%0d", k);
    e = v.ep;
    n = v.zlp ? 0 : ((v.last && v.len <= MAXP) ? v.len : MAXP);
    clear_counts();
    rdy_mode = v.mode;
    if (v.hs) begin
      hs_pid = v.pid;
      push_pkt(1'b1, v.pid, 0, 0, 1'b0, 16'h0);
      hs_req = 1'b1;
    end else begin
      setup_ep(e, v.pid, v.zlp, v.len, v.last, v.base);
      push_pkt(1'b0, v.pid, e, n, v.crc_k, v.crc);
      ep_req[e] = 1'b1;
    end
    budget = 0;
    while ((v.hs ? n_hs : n_done[e]) == 0 && budget < 3000) begin
      step();
      budget++;
    end
    if (budget >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no done after %0d cycles", tag, budget);
    end
    repeat (IPG + 4) step();
    check({tag, "_bytes_left"}, exp_q.size(), 0);
    check({tag, "_busy_idle"}, {31'h0, busy}, 32'd0);
    if (v.hs) begin
      check({tag, "_hs_done"}, n_hs, 1);
    end else begin
      check({tag, "_rd"}, n_rd[e], n);
      check({tag, "_done"}, n_done[e], 1);
      check({tag, "_trunc"}, n_trunc[e], {31'h0, v.trunc});
      check({tag, "_hs_none"}, n_hs, 0);
    end
  endtask

  initial begin
    int budget;
    tbl[0] = '{1'b1, 0, 4'b0010, 1'b0, 0,  1'b0, 8'h00, 1, 1'b0, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 1, 4'b0011, 1'b0, 9,  1'b1, 8'h31, 0, 1'b1, 16'hB4C8, 1'b0};
    tbl[2] = '{1'b0, 2, 4'b1011, 1'b1, 0,  1'b0, 8'h00, 2, 1'b1, 16'h0000, 1'b0};
    tbl[3] = '{1'b0, 3, 4'b1011, 1'b0, 64, 1'b1, 8'h80, 0, 1'b0, 16'h0000, 1'b0};
    tbl[4] = '{1'b0, 0, 4'b0011, 1'b0, 70, 1'b0, 8'hC0, 2, 1'b0, 16'h0000, 1'b1};
    tbl[5] = '{1'b1, 0, 4'b1010, 1'b0, 0,  1'b0, 8'h00, 0, 1'b0, 16'h0000, 1'b0};
    tbl[6] = '{1'b1, 0, 4'b1110, 1'b0, 0,  1'b0, 8'h00, 2, 1'b0, 16'h0000, 1'b0};
    tbl[7] = '{1'b0, 3, 4'b0011, 1'b0, 1,  1'b1, 8'h5A, 1, 1'b0, 16'h0000, 1'b0};
    exp_order[0] = 0; exp_order[1] = -1; exp_order[2] = 1;
    exp_order[3] = 2; exp_order[4] = 3;  exp_order[5] = 0;

    rst_n = 1'b0; tx_en = 1'b1; hs_req = 1'b0; hs_pid = 4'h0; tx_ready = 1'b1;
    ep_req = '0; ep_pid = '0; ep_zlp = '0; ep_data = '0; ep_last = '0;
    for (int e = 0; e < EP_N; e++) begin
      idx_a[e] = 0; len_a[e] = 0; last_a[e] = 0; base_a[e] = 8'h00; rearm[e] = 0;
    end
    cyc = 0; low_run = 0; prev_v = 0; seen_fall = 0; n_valid = 0; rdy_mode = 0;
    clear_counts();
    #12;
    check("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_hs_done", {31'h0, hs_done}, 32'd0);
    check("rst_data_in", {24'h0, data_in}, 32'd0);
    check("rst_ep_rd", {28'h0, ep_rd}, 32'd0);
    check("rst_ep_done", {28'h0, ep_done}, 32'd0);
    check("rst_ep_trunc", {28'h0, ep_trunc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Grant enable low: a pending request must not start, tx_ready alone does nothing.
    tx_en = 1'b0; hs_pid = 4'b1010; hs_req = 1'b1;
    repeat (20) step();
    check("txen_low_busy", {31'h0, busy}, 32'd0);
    check("txen_low_valid_cycles", n_valid, 0);
    hs_req = 1'b0; tx_en = 1'b1;
    repeat (2) step();

    for (int k = 0; k < 8; k++) run_vec(tbl[k], k);

    // All endpoints requesting, pointer at 3; handshake raised mid EP0 packet.
    clear_counts();
    done_log.delete();
    rdy_mode = 2;
    setup_ep(0, 4'b0011, 1'b0, 3, 1'b1, 8'h40);
    setup_ep(1, 4'b1011, 1'b0, 2, 1'b1, 8'h50);
    setup_ep(2, 4'b0011, 1'b0, 4, 1'b1, 8'h60);
    setup_ep(3, 4'b1011, 1'b0, 1, 1'b1, 8'h70);
    rearm[0] = 1;
    push_pkt(1'b0, 4'b0011, 0, 3, 1'b0, 16'h0);
    push_pkt(1'b1, 4'b1010, 0, 0, 1'b0, 16'h0);
    push_pkt(1'b0, 4'b1011, 1, 2, 1'b0, 16'h0);
    push_pkt(1'b0, 4'b0011, 2, 4, 1'b0, 16'h0);
    push_pkt(1'b0, 4'b1011, 3, 1, 1'b0, 16'h0);
    push_pkt(1'b0, 4'b0011, 0, 3, 1'b0, 16'h0);
    ep_req = '1;
    budget = 0;
    while (n_rd[0] == 0 && budget < 500) begin step(); budget++; end
    hs_pid = 4'b1010; hs_req = 1'b1;
    while (done_log.size() < 6 && budget < 4000) begin step(); budget++; end
    if (budget >= 4000) begin
      n_cmp++; n_bad++;
      $display("FAIL rr_timeout: %0d packets done", done_log.size());
    end
    repeat (IPG + 4) step();
    check("rr_count", done_log.size(), 6);
    for (int i = 0; i < 6 && i < done_log.size(); i++)
      check($sformatf("rr_order%0d", i), done_log[i], exp_order[i]);
    check("rr_bytes_left", exp_q.size(), 0);

    // Reset during the third payload byte, then a fresh packet from PID.
    clear_counts();
    rdy_mode = 0;
    setup_ep(1, 4'b0011, 1'b0, 9, 1'b1, 8'h31);
    push_pkt(1'b0, 4'b0011, 1, 9, 1'b1, 16'hB4C8);
    ep_req[1] = 1'b1;
    budget = 0;
    while (n_rd[1] < 2 && budget < 200) begin step(); budget++; end
    check("mid_rst_in_data", {31'h0, tx_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'd0);
    check("mid_rst_busy", {31'h0, busy}, 32'd0);
    check("mid_rst_ep_rd", {28'h0, ep_rd}, 32'd0);
    ep_req = '0;
    exp_q.delete();
    prev_v = 0; seen_fall = 0; low_run = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{1'b0, 1, 4'b1011, 1'b1, 0, 1'b0, 8'h00, 0, 1'b1, 16'h0000, 1'b0}, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
